muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Consumes the same operand pair the ALU sees.
- Its result is muxed onto the execute result bus when `done` is high.
- Hazard control holds the pipeline while `busy` is high.
- Iterative radix-2: one partial-product or quotient bit per cycle.

---
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};
    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic             r_sa;
    logic             r_sb;
    logic             r_special;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;

    // Launch-time decode of signedness, magnitudes and special division cases
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_spec_val;

    assign w_sa = inA[WIDTH-1] & ((op == c_OP_MULH) | (op == c_OP_MULHSU) |
                                  (op == c_OP_DIV)  | (op == c_OP_REM));
    assign w_sb = inB[WIDTH-1] & ((op == c_OP_MULH) | (op == c_OP_DIV) | (op == c_OP_REM));
    assign w_mag_a = w_sa ? (~inA + 1'b1) : inA;
    assign w_mag_b = w_sb ? (~inB + 1'b1) : inB;
    assign w_div0  = op[2] & (inB == '0);
    assign w_ovf   = ((op == c_OP_DIV) | (op == c_OP_REM)) & (inA == c_INT_MIN) & (inB == c_ONES);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        w_spec_val = '0;
        if (w_div0)
            w_spec_val = op[1] ? inA : c_ONES;
        else if (w_ovf)
            w_spec_val = op[1] ? '0 : c_INT_MIN;
    end

    // Multiply step: add multiplicand into the high half, shift {hi,lo} right
    logic [WIDTH:0] w_add;
    assign w_add = {1'b0, r_hi} + {1'b0, r_mag_a};

    // Divide step: shift next dividend bit into the remainder, trial-subtract
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    assign w_shift    = {r_hi, r_lo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_mag_b});
    assign w_rem_next = w_shift[WIDTH-1:0] - r_mag_b;

    // Sign fix-up of the finished magnitude result
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_final;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem_fix  = r_sa ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        w_final = w_prod_fix[2*WIDTH-1:WIDTH];
        if (r_special)
            w_final = r_lo;
        else if (r_op == c_OP_MUL)
            w_final = w_prod_fix[WIDTH-1:0];
        else if ((r_op == c_OP_DIV) || (r_op == c_OP_DIVU))
            w_final = w_quo_fix;
        else if (r_op[2])
            w_final = w_rem_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_special <= 1'b0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op    <= op;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        busy    <= 1'b1;
                        if (w_special) begin
                            r_special <= 1'b1;
                            r_lo      <= w_spec_val;
                            r_state   <= S_DONE;
                        end else begin
                            r_special <= 1'b0;
                            r_lo      <= op[2] ? w_mag_a : w_mag_b;
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_op[2]) begin
                            r_hi <= w_ge ? w_rem_next : w_shift[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], w_ge};
                        end else if (r_lo[0]) begin
                            r_hi <= w_add[WIDTH:1];
                            r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
                        end else begin
                            r_hi <= {1'b0, r_hi[WIDTH-1:1]};
                            r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH-1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                    if (!flush) begin
                        result <= w_final;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed and randomized self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] last_res;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .inA    (inA),
        .inB    (inB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit arithmetic and SV signed division
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int          sa;
        int          sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (o == 3'd1 || o == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb  = (o == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = ea * eb;
        case (o)
            3'd0:    return p[31:0];
            3'd1,
            3'd2,
            3'd3:    return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return o[2] && ((b == 0) ||
               ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // One operation; poke>=0 pulses a stray start at that busy cycle
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int poke, input string tag);
        int lat;
        int cyc;
        bit busy_ok;
        lat = is_special(o, a, b) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); inA = $urandom; inB = $urandom;
        cyc = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " result"}, result, exp);
        last_res = exp;
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; inA = '0; inB = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, -1, "MUL");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, "MULHU");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1, "MULH");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, -1, "MULHSU");
        run_op(3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD, -1, "DIV");
        run_op(3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF, -1, "REM");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, -1, "DIVU");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, -1, "REMU");
        run_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, -1, "DIVU_by0");
        run_op(3'd6, 32'h1234, 32'd0, 32'h1234, -1, "REM_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, "DIV_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, "REM_ovf");

        // Stray start pulses during CALC and during DONE must be ignored
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 12, "MUL_start_calc");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 32, "DIVU_start_done");

        // start together with flush in IDLE is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; inA = 32'd3; inB = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush busy", 32'(busy), 32'd0);

        // Flush at CALC cycle 10
        @(negedge clk);
        start = 1'b1; op = 3'd0; inA = 32'd5; inB = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, last_res);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("flush no_done", 32'(seen), 32'd0);

        // Reset at CALC cycle 5
        @(negedge clk);
        start = 1'b1; op = 3'd4; inA = 32'd1000; inB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("midrst no_done", 32'(seen), 32'd0);

        // Randomized regression against the reference model
        for (int i = 0; i < 800; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ro, ra, rb, ref_model(ro, ra, rb), -1, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
